// File: rtl/rgmii_tx_fmt.sv
// ---------------------------------------------------------------------------
// rgmii_tx_fmt
//   RGMII transmit formatter. Turns a byte-wide GMII-style stream into the
//   per-edge (d1 = rising half, d2 = falling half) pairs that a generic
//   output-DDR flop stage needs for TXD[3:0], TX_CTL and TXC.
//     1G     : one byte per clk, low nibble on d1, high nibble on d2.
//     10/100 : one nibble per TXC period (SDR, d1 == d2). TXC is made by
//              dividing clk by DIV_100 / DIV_10.
//   Every output is driven straight from a flop.
//
// Optional feature macro: RGMII_TX_ER_EN
//   defined   : in_er is honoured, ctl_d2 = in_en ^ in_er
//               (en=0, er=1 gives carrier extend: ctl 0/1).
//   undefined : in_er is ignored and ctl_d2 always equals ctl_d1.
//
// Ports
//   clk          in   125 MHz TX clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   speed[1:0]   in   00=10M, 01=100M, 1x=1G (applied only while idle)
//   in_data[7:0] in   byte to transmit
//   in_en        in   GMII TX_EN
//   in_er        in   GMII TX_ER
//   in_ready     out  one-cycle pulse: in_* are sampled at the end of this
//                     cycle, upstream presents the next byte afterwards
//   txd_d1/d2    out  TXD rising/falling halves
//   ctl_d1/d2    out  TX_CTL rising/falling halves
//   txc_d1/d2    out  TXC rising/falling halves
//   dbg_state_o  out  nibble FSM state (0 = NIB_LO, 1 = NIB_HI)
//
// Handshake: a byte is transferred on every rising clk edge that ends a
// cycle in which in_ready is 1; there is no backpressure from upstream,
// so in_data/in_en/in_er must be valid whenever in_ready is 1.
// ---------------------------------------------------------------------------
module rgmii_tx_fmt #(
  parameter int DIV_100 = 5,
  parameter int DIV_10  = 50,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic [7:0] in_data,
  input  logic       in_en,
  input  logic       in_er,
  output logic       in_ready,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       ctl_d1,
  output logic       ctl_d2,
  output logic       txc_d1,
  output logic       txc_d2,
  output logic       dbg_state_o
);

  typedef enum logic {NIB_LO = 1'b0, NIB_HI = 1'b1} nib_state_e;

  // Per-speed phase constants: last phase, TXC high length, launch point.
  localparam logic [CNT_W-1:0] M1_100  = CNT_W'(DIV_100 - 1);
  localparam logic [CNT_W-1:0] M1_10   = CNT_W'(DIV_10 - 1);
  localparam logic [CNT_W-1:0] H_100   = CNT_W'(DIV_100 / 2);
  localparam logic [CNT_W-1:0] H_10    = CNT_W'(DIV_10 / 2);
  localparam logic [CNT_W-1:0] L_100   = CNT_W'((DIV_100 + 1) / 2);
  localparam logic [CNT_W-1:0] L_10    = CNT_W'((DIV_10 + 1) / 2);
  localparam logic             ODD_100 = (DIV_100 % 2) == 1;
  localparam logic             ODD_10  = (DIV_10 % 2) == 1;

  nib_state_e       state_q, state_d;
  logic [1:0]       spd_q, spd_d;
  logic             spd_vld_q, spd_vld_d;   // spd_q holds a sampled value
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       txc_q, txc_d;
  logic [3:0]       txd1_q, txd2_q;
  logic             ctl1_q, ctl2_q;
  logic [3:0]       hi_q;                   // stored high nibble
  logic             en_q, er_q;             // stored byte's en/er

  logic             load, spd_chg, slow_q, launch, er_eff;

`ifdef RGMII_TX_ER_EN
  assign er_eff = in_er;
`else
  assign er_eff = 1'b0;
  logic unused_er;
  assign unused_er = in_er;
`endif

  function automatic logic [CNT_W-1:0] launch_pt(input logic s100);
    return s100 ? L_100 : L_10;
  endfunction

  function automatic logic [CNT_W-1:0] last_ph(input logic s100);
    return s100 ? M1_100 : M1_10;
  endfunction

  // TXC high for the first floor(D/2) phases; an odd divider spends the
  // middle phase as a half-high cycle so the duty cycle stays at 50%.
  function automatic logic [1:0] txc_pat(input logic [CNT_W-1:0] ph,
                                         input logic s100);
    logic [CNT_W-1:0] h;
    logic             odd;
    h   = s100 ? H_100 : H_10;
    odd = s100 ? ODD_100 : ODD_10;
    if (ph < h)                 return 2'b11;
    else if (odd && (ph == h))  return 2'b10;
    else                        return 2'b00;
  endfunction

  always_comb begin
    // Speed may only move between frames, with no nibble pending.
    load      = !in_en && (state_q == NIB_LO);
    spd_d     = load ? speed : spd_q;
    spd_vld_d = spd_vld_q | load;
    spd_chg   = load && (!spd_vld_q || (speed != spd_q));

    slow_q = spd_vld_q && !spd_q[1];
    launch = slow_q && (phase_q == launch_pt(spd_q[0]));

    state_d = state_q;
    if (launch) state_d = (state_q == NIB_LO) ? NIB_HI : NIB_LO;
    if (spd_vld_d && spd_d[1]) state_d = NIB_LO;

    if (spd_chg || !spd_vld_d || spd_d[1])      phase_d = '0;
    else if (phase_q == last_ph(spd_d[0]))      phase_d = '0;
    else                                        phase_d = phase_q + CNT_W'(1);

    // in_ready and TXC are computed from next-state values so that the
    // registered copies line up with the phase of the cycle they appear in.
    in_ready_d = 1'b0;
    txc_d      = 2'b00;
    if (spd_vld_d) begin
      if (spd_d[1]) begin
        in_ready_d = 1'b1;
        txc_d      = 2'b10;
      end else begin
        in_ready_d = (phase_d == launch_pt(spd_d[0])) && (state_d == NIB_LO);
        txc_d      = txc_pat(phase_d, spd_d[0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NIB_LO;
      spd_q      <= 2'b00;
      spd_vld_q  <= 1'b0;
      phase_q    <= '0;
      in_ready_q <= 1'b0;
      txc_q      <= 2'b00;
      txd1_q     <= 4'h0;
      txd2_q     <= 4'h0;
      ctl1_q     <= 1'b0;
      ctl2_q     <= 1'b0;
      hi_q       <= 4'h0;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      spd_q      <= spd_d;
      spd_vld_q  <= spd_vld_d;
      phase_q    <= phase_d;
      in_ready_q <= in_ready_d;
      txc_q      <= txc_d;
      if (spd_vld_q && spd_q[1]) begin
        txd1_q <= in_data[3:0];
        txd2_q <= in_data[7:4];
        ctl1_q <= in_en;
        ctl2_q <= in_en ^ er_eff;
      end else if (launch && (state_q == NIB_LO)) begin
        txd1_q <= in_data[3:0];
        txd2_q <= in_data[3:0];
        ctl1_q <= in_en;
        ctl2_q <= in_en ^ er_eff;
        hi_q   <= in_data[7:4];
        en_q   <= in_en;
        er_q   <= er_eff;
      end else if (launch) begin
        txd1_q <= hi_q;
        txd2_q <= hi_q;
        ctl1_q <= en_q;
        ctl2_q <= en_q ^ er_q;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign txd_d1      = txd1_q;
  assign txd_d2      = txd2_q;
  assign ctl_d1      = ctl1_q;
  assign ctl_d2      = ctl2_q;
  assign txc_d1      = txc_q[1];
  assign txc_d2      = txc_q[0];
  assign dbg_state_o = (state_q == NIB_HI);

endmodule

// File: tb/tb_rgmii_tx_fmt.sv
// ---------------------------------------------------------------------------
// tb_rgmii_tx_fmt
//   Bench for rgmii_tx_fmt. Randomised byte streams are fed through a
//   ready-driven source; expected values come from a timeline model: for a
//   10/100 segment starting at cycle k=0 (first cycle with phase 0), TXC,
//   in_ready and the launched nibble are pure arithmetic on k, D and the byte
//   list; for 1G the output is the byte presented one cycle earlier.
// ---------------------------------------------------------------------------
module tb_rgmii_tx_fmt;

  localparam int D100 = 5;
  localparam int D10  = 50;
`ifdef RGMII_TX_ER_EN
  localparam logic ER_ON = 1'b1;
`else
  localparam logic ER_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] speed;
  logic [7:0] in_data;
  logic       in_en, in_er;
  logic       in_ready;
  logic [3:0] txd_d1, txd_d2;
  logic       ctl_d1, ctl_d2, txc_d1, txc_d2, dbg_state_o;

  always #4 clk = ~clk;

  rgmii_tx_fmt #(.DIV_100(D100), .DIV_10(D10), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .speed(speed),
    .in_data(in_data), .in_en(in_en), .in_er(in_er),
    .in_ready(in_ready),
    .txd_d1(txd_d1), .txd_d2(txd_d2),
    .ctl_d1(ctl_d1), .ctl_d2(ctl_d2),
    .txc_d1(txc_d1), .txc_d2(txc_d2),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] b_data [512];
  logic       b_en   [512];
  logic       b_er   [512];
  int         ptr      = 0;
  int         seg_base = 0;
  int         base1    = 0;
  logic [7:0] last_d;
  logic       last_en, last_er;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ctl2_of(input logic en, input logic er);
    return en ^ (er & ER_ON);
  endfunction

  // ---------------- driver ----------------
  task automatic apply();
    in_data = b_data[ptr];
    in_en   = b_en[ptr];
    in_er   = b_er[ptr];
  endtask

  task automatic set_frame(input int i);
    b_data[i] = 8'($urandom_range(0, 255));
    b_en[i]   = 1'b1;
    b_er[i]   = ($urandom_range(0, 7) == 0);
  endtask

  // One clock: remember what was presented, and advance the source after an
  // edge that consumed it. Returns #1 after the edge.
  task automatic tick();
    logic rdy;
    rdy     = in_ready;
    last_d  = in_data;
    last_en = in_en;
    last_er = in_er;
    @(posedge clk);
    #1;
    if (rdy === 1'b1) begin
      ptr++;
      apply();
    end
  endtask

  // ---------------- reference model checks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_rdy"}, 8'(in_ready), 8'h00);
    check({tag, "_txd"}, 8'({txd_d1, txd_d2}), 8'h00);
    check({tag, "_ctl"}, 8'({ctl_d1, ctl_d2}), 8'h00);
    check({tag, "_txc"}, 8'({txc_d1, txc_d2}), 8'h00);
    check({tag, "_st"},  8'(dbg_state_o), 8'h00);
  endtask

  task automatic slow_check(input int k, input int d);
    int         l, h, p, n, idx;
    logic [1:0] et;
    logic [3:0] nib;
    logic       rdy_exp;
    l = (d + 1) / 2;
    h = d / 2;
    p = k % d;
    if (p < h)                      et = 2'b11;
    else if ((d % 2 == 1) && p == h) et = 2'b10;
    else                            et = 2'b00;
    rdy_exp = (k >= l) && (((k - l) % (2 * d)) == 0);
    check("slow_txc", 8'({txc_d1, txc_d2}), 8'(et));
    check("slow_rdy", 8'(in_ready), 8'(rdy_exp));
    if (k > l) begin
      n   = (k - l - 1) / d;          // launches already visible
      idx = seg_base + n / 2;
      nib = (n % 2 == 1) ? b_data[idx][7:4] : b_data[idx][3:0];
      check("slow_txd1", 8'(txd_d1), 8'(nib));
      check("slow_txd2", 8'(txd_d2), 8'(nib));
      check("slow_ctl1", 8'(ctl_d1), 8'(b_en[idx]));
      check("slow_ctl2", 8'(ctl_d2), 8'(ctl2_of(b_en[idx], b_er[idx])));
    end
  endtask

  task automatic fast_check(input int k);
    check("g_rdy", 8'(in_ready), 8'h01);
    check("g_txc", 8'({txc_d1, txc_d2}), 8'h02);
    if (k >= 1) begin
      check("g_txd1", 8'(txd_d1), 8'(last_d[3:0]));
      check("g_txd2", 8'(txd_d2), 8'(last_d[7:4]));
      check("g_ctl1", 8'(ctl_d1), 8'(last_en));
      check("g_ctl2", 8'(ctl_d2), 8'(ctl2_of(last_en, last_er)));
    end
  endtask

  task automatic run_slow(input int d, input int k_end, input int k_spd, input logic [1:0] new_spd);
    for (int k = 0; k <= k_end; k++) begin
      if (k == k_spd) speed = new_spd;
      slow_check(k, d);
      tick();
    end
  endtask

  task automatic run_fast(input int n, input logic [1:0] new_spd);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) speed = new_spd;
      fast_check(k);
      tick();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 512; i++) begin
      b_data[i] = 8'($urandom_range(0, 255));
      b_en[i]   = 1'b0;
      b_er[i]   = ($urandom_range(0, 3) == 0);
    end

    // Reset at 100M; leading idle byte, then a 5-byte frame starting 3C,7E.
    rst_n = 1'b0;
    speed = 2'b01;
    for (int i = 1; i <= 5; i++) set_frame(i);
    b_data[1] = 8'h3C; b_er[1] = 1'b0;
    b_data[2] = 8'h7E; b_er[2] = 1'b0;
    ptr = 0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    tick();                       // first idle edge loads the speed
    seg_base = ptr;

    // 100M frame; speed moves to 1G mid-frame and takes effect after the
    // high nibble of the last frame byte (k = 3 + 11*5 + 1 = 59).
    run_slow(D100, 59, 15, 2'b10);

    // 1G: A5 then 55 with er, random frame, idle, then switch to 10M.
    base1 = ptr;
    for (int i = 1; i <= 23; i++) set_frame(base1 + i);
    b_data[base1 + 1] = 8'hA5; b_er[base1 + 1] = 1'b0;
    b_data[base1 + 2] = 8'h55; b_er[base1 + 2] = 1'b1;
    b_en[base1 + 24] = 1'b0;
    set_frame(base1 + 25); b_data[base1 + 25] = 8'h3C; b_er[base1 + 25] = 1'b0;
    set_frame(base1 + 26); b_data[base1 + 26] = 8'h7E; b_er[base1 + 26] = 1'b0;
    set_frame(base1 + 27);
    b_en[base1 + 28] = 1'b0;
    run_fast(25, 2'b00);

    // 10M frame of 3 bytes; mid-frame request for 100M lands at
    // k = 25 + 5*50 + 1 = 276.
    seg_base = ptr;
    run_slow(D10, 276, 127, 2'b01);

    // 100M frame interrupted by reset while in NIB_HI.
    seg_base = ptr;
    for (int i = 1; i <= 3; i++) set_frame(ptr + i);
    run_slow(D100, 14, -1, 2'b01);
    slow_check(15, D100);
    check("mid_state_hi", 8'(dbg_state_o), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    b_en[ptr] = 1'b0;
    for (int i = 1; i <= 3; i++) set_frame(ptr + i);
    b_en[ptr + 4] = 1'b0;
    apply();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_zero("rst_hold");
    rst_n = 1'b1;
    tick();
    seg_base = ptr;
    run_slow(D100, 43, -1, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
